// File: rtl/req_encoder32to5_pkg.sv
// rtl/req_encoder32to5_pkg.sv - shared sizes and offer-state encoding for the request encoder
package req_encoder32to5_pkg;
  localparam int N = 32;
  localparam int W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;
endpackage

// File: rtl/req_encoder32to5_if.sv
// rtl/req_encoder32to5_if.sv - request/offer bus between producers, encoder and consumer
interface req_encoder32to5_if
  import req_encoder32to5_pkg::*;
  ();
  logic         en;
  logic [N-1:0] req;
  logic         ready;
  logic         valid;
  logic [W-1:0] idx;
  logic         busy;

  modport master (output en, output req, output ready,
                  input valid, input idx, input busy);
  modport slave  (input en, input req, input ready,
                  output valid, output idx, output busy);
endinterface

// File: rtl/req_encoder32to5_rr.sv
// rtl/req_encoder32to5_rr.sv - combinational round-robin first-set-bit finder
module rr_priority_encoder32
  import req_encoder32to5_pkg::*;
  (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
  );

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;

  // Rotate so that index ptr lands at bit 0, then take the lowest set bit.
  always_comb begin
    dbl = {mask, mask} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    found = |mask;
    idx   = ptr + off;
  end
endmodule

// File: rtl/req_encoder32to5.sv
// rtl/req_encoder32to5.sv - sticky 32-line request collector with round-robin registered offer
module req_encoder32to5
  import req_encoder32to5_pkg::*;
  #(
    parameter int N_REQ = req_encoder32to5_pkg::N,
    parameter int W_IDX = req_encoder32to5_pkg::W
  )
  (
    input  logic               clk_i,
    input  logic               rst_i,
    req_encoder32to5_if.slave  bus
  );

  logic [N_REQ-1:0] pending_q, pending_d, clr, masked;
  logic [W_IDX-1:0] ptr_q, ptr_d, idx_q, sel_idx;
  logic             valid_q, accept, found;
  state_e           state_q;

  // Selection sees the post-accept pointer so back-to-back offers advance round-robin.
  always_comb begin
    accept    = valid_q & bus.ready;
    clr       = accept ? (N_REQ'(1) << idx_q) : '0;
    masked    = pending_q & ~clr;
    pending_d = masked | bus.req;
    ptr_d     = accept ? idx_q + W_IDX'(1) : ptr_q;
  end

  rr_priority_encoder32 u_rr (
    .mask  (masked),
    .ptr   (ptr_d),
    .found (found),
    .idx   (sel_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      state_q   <= IDLE;
    end else begin
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      case (state_q)
        IDLE: begin
          if (bus.en && found) begin
            state_q <= OFFER;
            valid_q <= 1'b1;
            idx_q   <= sel_idx;
          end
        end
        OFFER: begin
          if (bus.ready) begin
            if (bus.en && found) begin
              idx_q <= sel_idx;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid = valid_q;
  assign bus.idx   = idx_q;
  assign bus.busy  = |pending_q;
endmodule

// File: doc/req_encoder32to5.md
REQ_ENCODER32TO5 -- requirements
Module: req_encoder32to5

Interface
REQ-001 Parameter N, default 32: number of request lines; fixed at 32 in this revision.
REQ-002 Parameter W, default 5: index width, equal to log2(N).
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset; asynchronous and active-high.
REQ-005 EN  input  1  offer enable; when 0, no new offer is started.
REQ-006 REQ  input  32  request pulses; bit i set means source i is requesting service.
REQ-007 READY  input  1  consumer accepts the current offer when READY=1 and VALID=1.
REQ-008 VALID  output  1  IDX holds a valid encoded request.
REQ-009 IDX  output  5  binary index of the offered request.
REQ-010 BUSY  output  1  OR of all pending bits.

Function
REQ-011 The block shall hold a 32-bit pending register; each REQ bit is sticky until its index is accepted.
REQ-012 The next pending value shall be (pending AND NOT clr) OR REQ, where clr is one-hot(IDX) when VALID and READY are both 1, and zero otherwise.
REQ-013 If REQ bit i rises in the same cycle that index i is accepted, bit i shall remain set.
REQ-014 The block shall keep a 5-bit round-robin pointer PTR; on acceptance of index i, PTR becomes (i+1) mod 32, so 31 wraps to 0.
REQ-015 Selection shall pick the first set bit of (pending AND NOT clr), scanning indices PTR, PTR+1, ... mod 32.
REQ-016 Offer states: IDLE (VALID=0) and OFFER (VALID=1).
REQ-017 IDLE to OFFER: EN=1 and a selectable bit exists; IDX is registered and VALID=1 the next cycle.
REQ-018 OFFER with READY=0: IDX and VALID shall hold stable regardless of EN, REQ or PTR.
REQ-019 OFFER with READY=1: if EN=1 and another selectable bit exists, stay in OFFER with the new IDX next cycle, so back-to-back offers have no bubble; otherwise go to IDLE.
REQ-020 Minimum latency shall be 2 cycles: REQ at edge t, pending set at t+1, VALID at t+2.
REQ-021 An index under offer shall never be offered again until accepted and re-requested.
REQ-022 BUSY shall be registered-derived: the OR of the current pending register, with no dependence on REQ in the same cycle.
REQ-023 There shall be no combinational path from READY or REQ to VALID or IDX.

Reset
REQ-024 While RST=1, the block shall set pending=0, PTR=0, VALID=0, IDX=0 and BUSY=0 immediately, independent of CLK.
REQ-025 Reset asserted mid-offer shall drop VALID without completing the handshake; the pending request is lost.
REQ-026 On the first rising edge after RST falls, REQ shall be captured normally.

Structure
REQ-027 A shared package shall hold N, W and the state encoding (IDLE, OFFER).
REQ-028 Round-robin selection shall be one combinational sub-module, rr_priority_encoder32, with inputs (mask[31:0], ptr[4:0]) and outputs (found, idx[4:0]).
REQ-029 The top level shall contain only the pending register, PTR, the state and output registers, and the clear logic.

Verification
REQ-030 Single request: REQ=0x00000008 for 1 cycle with EN=1, READY=1 -> VALID=1, IDX=3 two cycles later for exactly 1 cycle; PTR=4; BUSY returns to 0.
REQ-031 Round-robin order: REQ=0x80000011 pulsed once, READY=1 -> IDX sequence 0, 4, 31 on consecutive cycles, then VALID=0; PTR=0 after the wrap.
REQ-032 Backpressure: pending=0x00000006, READY=0 for 5 cycles while REQ=0x00000001 pulses -> IDX=1 stable all 5 cycles; after READY=1 -> IDX 2, then 0.
REQ-033 Simultaneous set and clear: REQ bit 7 pulsed in the same cycle index 7 is accepted -> index 7 is offered again after the other pending bits ahead of it in round-robin order.
REQ-034 Enable gating: EN=0 with pending=0x00000100 -> VALID stays 0 and BUSY=1; EN=1 -> IDX=8 the next cycle.
REQ-035 Async reset mid-offer: RST pulsed between clock edges during VALID=1 -> VALID, IDX, BUSY and PTR read 0 before the next edge.
